// File: rtl/rvfi_stream_checker.sv
// rvfi_stream_checker
//   Observes an RVFI retire stream and keeps a shadow register file, the
//   expected next PC, the expected retire order and the halt state. It checks
//   every retired lane against them. The first violation is latched into
//   sticky registered outputs that hold until reset.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   rvfi_valid/order/trap/halt  per-lane retire strobe, index, trap, final
//   rvfi_rs{1,2}_addr/rdata     per-lane source register index and value read
//   rvfi_rd_addr/wdata          per-lane destination index and value written
//   rvfi_pc_rdata/wdata         per-lane PC and next PC
//   err                         sticky first-violation flag
//   err_code                    1 PACK, 2 HALT, 3 ORDER, 4 PC, 5 RS1, 6 RS2, 7 X0
//   err_lane, err_order         lane and rvfi_order of the first violation
//   retired                     total retired instructions (wraps)
module rvfi_stream_checker #(
    parameter int unsigned NRET       = 1,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CHECK_REGS = 1,
    parameter int unsigned ORDER_W    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRET-1:0]            rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]    rvfi_order,
    input  logic [NRET-1:0]            rvfi_trap,
    input  logic [NRET-1:0]            rvfi_halt,
    input  logic [NRET*5-1:0]          rvfi_rs1_addr,
    input  logic [NRET*5-1:0]          rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0]       rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]       rvfi_rs2_rdata,
    input  logic [NRET*5-1:0]          rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]       rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0]       rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]       rvfi_pc_wdata,
    output logic                       err,
    output logic [2:0]                 err_code,
    output logic [$clog2(NRET):0]      err_lane,
    output logic [ORDER_W-1:0]         err_order,
    output logic [ORDER_W-1:0]         retired
);

    localparam int unsigned LANE_W = $clog2(NRET) + 1;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_PACK  = 3'd1;
    localparam logic [2:0] ERR_HALT  = 3'd2;
    localparam logic [2:0] ERR_ORDER = 3'd3;
    localparam logic [2:0] ERR_PC    = 3'd4;
    localparam logic [2:0] ERR_RS1   = 3'd5;
    localparam logic [2:0] ERR_RS2   = 3'd6;
    localparam logic [2:0] ERR_X0    = 3'd7;

    // Registered tracking state; x0 is never stored.
    logic [XLEN-1:0]    r_shadow [1:31];
    logic [31:1]        r_sh_vld;
    logic [ORDER_W-1:0] r_exp_order;
    logic [XLEN-1:0]    r_pc;
    logic               r_pc_known;
    logic               r_halted;
    logic               r_err;
    logic [2:0]         r_err_code;
    logic [LANE_W-1:0]  r_err_lane;
    logic [ORDER_W-1:0] r_err_order;
    logic [ORDER_W-1:0] r_retired;

    // Next-state chain: each lane sees the updates of the valid lanes below it.
    logic [XLEN-1:0]    w_shadow [1:31];
    logic [31:1]        w_sh_vld;
    logic [XLEN-1:0]    w_pc;
    logic               w_pc_known;
    logic               w_halted;
    logic [LANE_W-1:0]  w_cnt;
    logic               w_prev_valid;
    logic               w_hit;
    logic [2:0]         w_hit_code;
    logic [LANE_W-1:0]  w_hit_lane;
    logic [ORDER_W-1:0] w_hit_order;

    // Per-lane scratch
    logic [2:0]         w_code;
    logic [ORDER_W-1:0] w_ord;
    logic [4:0]         w_a1, w_a2, w_ad;
    logic [XLEN-1:0]    w_d1, w_d2, w_dd, w_pcr, w_pcw;
    logic               w_rs1_bad, w_rs2_bad, w_trap;

    always_comb begin
        w_shadow     = r_shadow;
        w_sh_vld     = r_sh_vld;
        w_pc         = r_pc;
        w_pc_known   = r_pc_known;
        w_halted     = r_halted;
        w_cnt        = '0;
        w_prev_valid = 1'b1;
        w_hit        = 1'b0;
        w_hit_code   = ERR_NONE;
        w_hit_lane   = '0;
        w_hit_order  = '0;
        w_code       = ERR_NONE;
        w_ord        = '0;
        w_a1         = '0;
        w_a2         = '0;
        w_ad         = '0;
        w_d1         = '0;
        w_d2         = '0;
        w_dd         = '0;
        w_pcr        = '0;
        w_pcw        = '0;
        w_rs1_bad    = 1'b0;
        w_rs2_bad    = 1'b0;
        w_trap       = 1'b0;

        for (int unsigned k = 0; k < NRET; k++) begin
            w_ord  = rvfi_order[k*ORDER_W +: ORDER_W];
            w_a1   = rvfi_rs1_addr[k*5 +: 5];
            w_a2   = rvfi_rs2_addr[k*5 +: 5];
            w_ad   = rvfi_rd_addr[k*5 +: 5];
            w_d1   = rvfi_rs1_rdata[k*XLEN +: XLEN];
            w_d2   = rvfi_rs2_rdata[k*XLEN +: XLEN];
            w_dd   = rvfi_rd_wdata[k*XLEN +: XLEN];
            w_pcr  = rvfi_pc_rdata[k*XLEN +: XLEN];
            w_pcw  = rvfi_pc_wdata[k*XLEN +: XLEN];
            w_trap = rvfi_trap[k];

            // Source checks compare against the shadow as it stood on entry to this lane.
            w_rs1_bad = 1'b0;
            w_rs2_bad = 1'b0;
            if (CHECK_REGS != 0) begin
                if (w_a1 == 5'd0) w_rs1_bad = (w_d1 != '0);
                else              w_rs1_bad = w_sh_vld[w_a1] && (w_d1 != w_shadow[w_a1]);
                if (w_a2 == 5'd0) w_rs2_bad = (w_d2 != '0);
                else              w_rs2_bad = w_sh_vld[w_a2] && (w_d2 != w_shadow[w_a2]);
            end

            w_code = ERR_NONE;
            if (rvfi_valid[k]) begin
                if (!w_prev_valid)                                w_code = ERR_PACK;
                else if (w_halted)                                w_code = ERR_HALT;
                else if (w_ord != r_exp_order + ORDER_W'(w_cnt))  w_code = ERR_ORDER;
                else if (w_pc_known && (w_pcr != w_pc))           w_code = ERR_PC;
                else if (w_rs1_bad)                               w_code = ERR_RS1;
                else if (w_rs2_bad)                               w_code = ERR_RS2;
                else if ((w_ad == 5'd0) && (w_dd != '0))          w_code = ERR_X0;

                if ((w_code != ERR_NONE) && !w_hit) begin
                    w_hit       = 1'b1;
                    w_hit_code  = w_code;
                    w_hit_lane  = LANE_W'(k);
                    w_hit_order = w_ord;
                end

                // First read of an unknown register adopts the observed value.
                if (CHECK_REGS != 0) begin
                    if ((w_a1 != 5'd0) && !w_sh_vld[w_a1]) begin
                        w_shadow[w_a1] = w_d1;
                        w_sh_vld[w_a1] = 1'b1;
                    end
                    if ((w_a2 != 5'd0) && !w_sh_vld[w_a2]) begin
                        w_shadow[w_a2] = w_d2;
                        w_sh_vld[w_a2] = 1'b1;
                    end
                end

                if (!w_trap) begin
                    if (w_ad != 5'd0) begin
                        w_shadow[w_ad] = w_dd;
                        w_sh_vld[w_ad] = 1'b1;
                    end
                    w_pc       = w_pcw;
                    w_pc_known = 1'b1;
                end else begin
                    w_pc_known = 1'b0;
                end

                if (rvfi_halt[k]) w_halted = 1'b1;
                w_cnt = w_cnt + LANE_W'(1);
            end
            w_prev_valid = rvfi_valid[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow    <= '{default: '0};
            r_sh_vld    <= '0;
            r_exp_order <= '0;
            r_pc        <= '0;
            r_pc_known  <= 1'b0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_lane  <= '0;
            r_err_order <= '0;
            r_retired   <= '0;
        end else begin
            r_shadow    <= w_shadow;
            r_sh_vld    <= w_sh_vld;
            r_pc        <= w_pc;
            r_pc_known  <= w_pc_known;
            r_halted    <= w_halted;
            r_exp_order <= r_exp_order + ORDER_W'(w_cnt);
            r_retired   <= r_retired + ORDER_W'(w_cnt);
            if (!r_err && w_hit) begin
                r_err       <= 1'b1;
                r_err_code  <= w_hit_code;
                r_err_lane  <= w_hit_lane;
                r_err_order <= w_hit_order;
            end
        end
    end

    assign err       = r_err;
    assign err_code  = r_err_code;
    assign err_lane  = r_err_lane;
    assign err_order = r_err_order;
    assign retired   = r_retired;

endmodule

// File: tb/tb_rvfi_stream_checker.sv
module tb_rvfi_stream_checker;

    localparam int unsigned NRET = 2;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OW   = 8;

    logic                 clk;
    logic                 reset;
    logic [NRET-1:0]      valid, trap, halt;
    logic [NRET*OW-1:0]   order;
    logic [NRET*5-1:0]    rs1a, rs2a, rda;
    logic [NRET*XLEN-1:0] rs1d, rs2d, rdd, pcr, pcw;
    logic                 err;
    logic [2:0]           err_code;
    logic [1:0]           err_lane;
    logic [OW-1:0]        err_order;
    logic [OW-1:0]        retired;

    int checks   = 0;
    int failures = 0;

    rvfi_stream_checker #(
        .NRET(NRET), .XLEN(XLEN), .CHECK_REGS(1), .ORDER_W(OW)
    ) dut (
        .clk(clk), .reset(reset),
        .rvfi_valid(valid), .rvfi_order(order), .rvfi_trap(trap), .rvfi_halt(halt),
        .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a),
        .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d),
        .rvfi_rd_addr(rda), .rvfi_rd_wdata(rdd),
        .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw),
        .err(err), .err_code(err_code), .err_lane(err_lane),
        .err_order(err_order), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_lanes();
        valid = '0; trap = '0; halt = '0; order = '0;
        rs1a = '0; rs2a = '0; rda = '0;
        rs1d = '0; rs2d = '0; rdd = '0; pcr = '0; pcw = '0;
    endtask

    task automatic set_lane(input int ln, input logic [OW-1:0] o, input logic tr, input logic hl,
                            input logic [4:0] a1, input logic [31:0] d1,
                            input logic [4:0] a2, input logic [31:0] d2,
                            input logic [4:0] ad, input logic [31:0] dd,
                            input logic [31:0] pr, input logic [31:0] pw);
        valid[ln] = 1'b1; trap[ln] = tr; halt[ln] = hl;
        order[ln*OW +: OW]  = o;
        rs1a[ln*5 +: 5]     = a1; rs1d[ln*XLEN +: XLEN] = d1;
        rs2a[ln*5 +: 5]     = a2; rs2d[ln*XLEN +: XLEN] = d2;
        rda[ln*5 +: 5]      = ad; rdd[ln*XLEN +: XLEN]  = dd;
        pcr[ln*XLEN +: XLEN] = pr; pcw[ln*XLEN +: XLEN] = pw;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        clear_lanes();
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; clear_lanes();
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
        checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", err_code); end
        checks++; if (retired !== 8'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    endtask

    task automatic test_inorder();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            // rs1 reads the register written by the previous instruction
            set_lane(0, OW'(i), 1'b0, 1'b0, 5'(i), 32'(i), 5'd0, 32'd0,
                     5'(i + 1), 32'(i + 1), 32'(4 * i), 32'(4 * i + 4));
            tick();
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL inorder_err%0d got=%0h exp=0 code=%0d", i, err, err_code); end
        end
        checks++; if (retired !== 8'd5) begin failures++; $display("FAIL inorder_retired got=%0d exp=5", retired); end
    endtask

    task automatic test_rs1();
        do_reset();
        set_lane(0, 8'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h1234, 32'h0, 32'h4);
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rs1_pre_err got=%0h exp=0", err); end
        set_lane(0, 8'd1, 1'b0, 1'b0, 5'd5, 32'h1235, 5'd0, 32'd0, 5'd0, 32'd0, 32'h4, 32'h8);
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rs1_err got=%0h exp=1", err); end
        checks++; if (err_code !== 3'd5) begin failures++; $display("FAIL rs1_code got=%0d exp=5", err_code); end
        checks++; if (err_lane !== 2'd0) begin failures++; $display("FAIL rs1_lane got=%0d exp=0", err_lane); end
        checks++; if (err_order !== 8'd1) begin failures++; $display("FAIL rs1_order got=%0d exp=1", err_order); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_lane(0, OW'(i), 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'(4 * i), 32'(4 * i + 4));
            tick();
        end
        set_lane(0, 8'd7, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'hAA, 32'h1C, 32'h20);
        set_lane(1, 8'd8, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 32'hAA, 5'd0, 32'd0, 32'h20, 32'h24);
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%0h exp=0 code=%0d", err, err_code); end
        checks++; if (retired !== 8'd9) begin failures++; $display("FAIL b2b_retired got=%0d exp=9", retired); end
        // lane1 reads a stale value after lane0 overwrote x3 in the same cycle
        set_lane(0, 8'd9,  1'b0, 1'b0, 5'd3, 32'hAA, 5'd0, 32'd0, 5'd3, 32'hBB, 32'h24, 32'h28);
        set_lane(1, 8'd10, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 32'hAA, 5'd0, 32'd0, 32'h28, 32'h2C);
        tick();
        checks++; if (err_code !== 3'd6) begin failures++; $display("FAIL fwd_code got=%0d exp=6", err_code); end
        checks++; if (err_lane !== 2'd1) begin failures++; $display("FAIL fwd_lane got=%0d exp=1", err_lane); end
        checks++; if (err_order !== 8'd10) begin failures++; $display("FAIL fwd_order got=%0d exp=10", err_order); end
    endtask

    task automatic test_pack();
        do_reset();
        set_lane(1, 8'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 32'h4);
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL pack_err got=%0h exp=1", err); end
        checks++; if (err_code !== 3'd1) begin failures++; $display("FAIL pack_code got=%0d exp=1", err_code); end
        checks++; if (err_lane !== 2'd1) begin failures++; $display("FAIL pack_lane got=%0d exp=1", err_lane); end
        checks++; if (retired !== 8'd1) begin failures++; $display("FAIL pack_retired got=%0d exp=1", retired); end
        set_lane(0, 8'd5, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h4, 32'h8);
        tick();
        checks++; if (err_code !== 3'd1) begin failures++; $display("FAIL sticky_code got=%0d exp=1", err_code); end
        checks++; if (err_lane !== 2'd1) begin failures++; $display("FAIL sticky_lane got=%0d exp=1", err_lane); end
        checks++; if (err_order !== 8'd0) begin failures++; $display("FAIL sticky_order got=%0d exp=0", err_order); end
    endtask

    task automatic test_trap_pc();
        do_reset();
        // trapped lane must not write x7
        set_lane(0, 8'd0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 32'h55, 32'h100, 32'h104);
        tick();
        set_lane(0, 8'd1, 1'b0, 1'b0, 5'd7, 32'h99, 5'd0, 32'd0, 5'd0, 32'd0, 32'h8000_0000, 32'h8000_0004);
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL trap_err got=%0h exp=0 code=%0d", err, err_code); end
        set_lane(0, 8'd2, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h8000_0008, 32'h8000_000C);
        tick();
        checks++; if (err_code !== 3'd4) begin failures++; $display("FAIL pc_code got=%0d exp=4", err_code); end
        checks++; if (err_order !== 8'd2) begin failures++; $display("FAIL pc_order got=%0d exp=2", err_order); end
    endtask

    task automatic test_x0();
        do_reset();
        set_lane(0, 8'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'h5, 32'h0, 32'h4);
        tick();
        checks++; if (err_code !== 3'd7) begin failures++; $display("FAIL x0_code got=%0d exp=7", err_code); end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_lane(0, OW'(i), 1'b0, (i == 3), 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'(4 * i), 32'(4 * i + 4));
            tick();
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL prehalt_err got=%0h exp=0", err); end
        set_lane(0, 8'd4, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h10, 32'h14);
        tick();
        checks++; if (err_code !== 3'd2) begin failures++; $display("FAIL halt_code got=%0d exp=2", err_code); end
        checks++; if (err_order !== 8'd4) begin failures++; $display("FAIL halt_order got=%0d exp=4", err_order); end
        // asynchronous reset, away from any clock edge
        #2 reset = 1'b1; #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL areset_err got=%0h exp=0", err); end
        checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL areset_code got=%0d exp=0", err_code); end
        checks++; if (err_order !== 8'd0) begin failures++; $display("FAIL areset_order got=%0d exp=0", err_order); end
        checks++; if (retired !== 8'd0) begin failures++; $display("FAIL areset_retired got=%0d exp=0", retired); end
        @(negedge clk); reset = 1'b0;
        set_lane(0, 8'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h200, 32'h204);
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL restart_err got=%0h exp=0 code=%0d", err, err_code); end
        checks++; if (retired !== 8'd1) begin failures++; $display("FAIL restart_retired got=%0d exp=1", retired); end
        // halt on lane0 makes lane1 in the same cycle a HALT violation
        do_reset();
        set_lane(0, 8'd0, 1'b0, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 32'h4);
        set_lane(1, 8'd1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h4, 32'h8);
        tick();
        checks++; if (err_code !== 3'd2) begin failures++; $display("FAIL samehalt_code got=%0d exp=2", err_code); end
        checks++; if (err_lane !== 2'd1) begin failures++; $display("FAIL samehalt_lane got=%0d exp=1", err_lane); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            set_lane(0, OW'(2 * i),     1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 32'h0);
            set_lane(1, OW'(2 * i + 1), 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 32'h0);
            tick();
        end
        checks++; if (retired !== 8'd0) begin failures++; $display("FAIL wrap_retired got=%0d exp=0", retired); end
        set_lane(0, 8'd0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 32'h0);
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%0h exp=0 code=%0d", err, err_code); end
        checks++; if (retired !== 8'd1) begin failures++; $display("FAIL wrap_retired1 got=%0d exp=1", retired); end
    endtask

    initial begin
        reset = 1'b1;
        clear_lanes();
        test_reset();
        test_inorder();
        test_rs1();
        test_back_to_back();
        test_pack();
        test_trap_pc();
        test_x0();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
